// File: rtl/oh_aomux_reg_if.sv
// Valid/ready stream bundle for oh_aomux_reg: N selectable channels in, one DW-bit result out.
interface oh_aomux_reg_if #(
  parameter int unsigned DW = 1,
  parameter int unsigned N  = 2
);
  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    sel;
  logic [N*DW-1:0] in;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   z;
  logic            error;

  // Producer/consumer side driving the block.
  modport master (
    output in_valid, sel, in, out_ready,
    input  in_ready, out_valid, z, error
  );

  // The block itself.
  modport slave (
    input  in_valid, sel, in, out_ready,
    output in_ready, out_valid, z, error
  );
endinterface

// File: rtl/oh_aomux_reg.sv
// Registered AND-OR multiplexer with a 2-entry output skid buffer.
// z = OR over i of (sel[i] & in[i]); in_ready and out_valid decode only registered state.
// Optional: define OH_AOMUX_ONECHK_EN to get a sticky multi-select error flag.
module oh_aomux_reg #(
  parameter int unsigned DW = 1,
  parameter int unsigned N  = 2
) (
  input  logic          clk,
  input  logic          nreset,
  oh_aomux_reg_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t          r_count;
  logic [DW-1:0]   r_head;
  logic [DW-1:0]   r_skid;
  logic            r_out_valid;
  logic            r_in_ready;

  logic [DW-1:0]   w_result;
  logic            w_accept;
  logic            w_pop;

  assign w_accept = bus.in_valid & r_in_ready;
  assign w_pop    = r_out_valid & bus.out_ready;

  // AND-OR reduction across channels; no priority between selected channels.
  always_comb begin
    w_result = '0;
    for (int i = 0; i < int'(N); i++) begin
      w_result = w_result | ({DW{bus.sel[i]}} & bus.in[i*DW +: DW]);
    end
  end

  // Skid-buffer FSM; status flags are updated together with the count so they stay registered.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_count     <= EMPTY;
      r_head      <= '0;
      r_skid      <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_count)
        EMPTY: begin
          if (w_accept) begin
            r_head      <= w_result;
            r_count     <= ONE;
            r_out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (w_accept && !w_pop) begin
            r_skid     <= w_result;
            r_count    <= TWO;
            r_in_ready <= 1'b0;
          end else if (w_accept && w_pop) begin
            r_head <= w_result;
          end else if (w_pop) begin
            // head is held; z is don't-care while out_valid is low
            r_count     <= EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        TWO: begin
          if (w_pop) begin
            r_head     <= r_skid;
            r_count    <= ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_count     <= EMPTY;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.z         = r_head;
  assign bus.out_valid = r_out_valid;
  assign bus.in_ready  = r_in_ready;

`ifdef OH_AOMUX_ONECHK_EN
  logic r_error;
  logic w_multi;

  // More than one select bit set: clearing the lowest set bit leaves something behind.
  assign w_multi = |(bus.sel & (bus.sel - N'(1)));

  // Sticky flag raised by any accepted multi-select beat.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_error <= 1'b0;
    end else if (w_accept && w_multi) begin
      r_error <= 1'b1;
    end
  end

  assign bus.error = r_error;
`else
  assign bus.error = 1'b0;
`endif

endmodule

// File: tb/tb_oh_aomux_reg.sv
// Directed bench for oh_aomux_reg: an 8-bit/4-channel instance and a 1-bit/2-channel instance.
module tb_oh_aomux_reg;

`ifdef OH_AOMUX_ONECHK_EN
  localparam bit ONECHK = 1'b1;
`else
  localparam bit ONECHK = 1'b0;
`endif

  logic clk;
  logic nreset;

  oh_aomux_reg_if #(.DW(8), .N(4)) b4 ();
  oh_aomux_reg_if #(.DW(1), .N(2)) b2 ();

  oh_aomux_reg #(.DW(8), .N(4)) u4 (.clk(clk), .nreset(nreset), .bus(b4));
  oh_aomux_reg #(.DW(1), .N(2)) u2 (.clk(clk), .nreset(nreset), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] din;
    logic [7:0]  z;
  } vec_t;

  vec_t vt [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic exp_err4;
  logic exp_err2;
  logic [7:0] beat;
  logic e;

  initial begin
    vt[0] = '{4'b0100, 32'h44332211, 8'h33};
    vt[1] = '{4'b0000, 32'h44332211, 8'h00};
    vt[2] = '{4'b0101, 32'h44332211, 8'h33};
    vt[3] = '{4'b1000, 32'h44332211, 8'h44};
    vt[4] = '{4'b0010, 32'hA55A0FF0, 8'h0F};
    vt[5] = '{4'b1001, 32'hA55A0FF0, 8'hF5};
    vt[6] = '{4'b1111, 32'h01020408, 8'h0F};
    vt[7] = '{4'b0001, 32'h01020408, 8'h08};

    exp_err4 = 1'b0;
    exp_err2 = 1'b0;

    b4.in_valid = 1'b0; b4.sel = '0; b4.in = '0; b4.out_ready = 1'b0;
    b2.in_valid = 1'b0; b2.sel = '0; b2.in = '0; b2.out_ready = 1'b0;
    nreset = 1'b1;
    #1 nreset = 1'b0;
    #2;
    check("rst_out_valid", 32'(b4.out_valid), 32'h0);
    check("rst_in_ready",  32'(b4.in_ready),  32'h1);
    check("rst_z",         32'(b4.z),         32'h0);
    check("rst_error",     32'(b4.error),     32'h0);
    check("rst2_out_valid", 32'(b2.out_valid), 32'h0);
    check("rst2_in_ready",  32'(b2.in_ready),  32'h1);
    @(negedge clk);
    nreset = 1'b1;
    step();
    check("idle_out_valid", 32'(b4.out_valid), 32'h0);

    // Table: one beat per cycle with out_ready=1, result visible one edge later.
    for (int i = 0; i < 8; i++) begin
      b4.sel = vt[i].sel;
      b4.in = vt[i].din;
      b4.in_valid = 1'b1;
      b4.out_ready = 1'b1;
      step();
      if (ONECHK && ($countones(vt[i].sel) > 1)) exp_err4 = 1'b1;
      check($sformatf("vec%0d_z", i),         32'(b4.z),         32'(vt[i].z));
      check($sformatf("vec%0d_out_valid", i), 32'(b4.out_valid), 32'h1);
      check($sformatf("vec%0d_in_ready", i),  32'(b4.in_ready),  32'h1);
      check($sformatf("vec%0d_error", i),     32'(b4.error),     32'(exp_err4));
    end
    b4.in_valid = 1'b0;
    step();
    check("drain_out_valid", 32'(b4.out_valid), 32'h0);

    // Backpressure: A, B fill both entries; C must wait for space.
    b4.sel = 4'b0001;
    b4.out_ready = 1'b0;
    b4.in_valid = 1'b1;
    b4.in = 32'h000000A1;
    step();
    check("bp_a_z", 32'(b4.z), 32'hA1);
    check("bp_a_in_ready", 32'(b4.in_ready), 32'h1);
    b4.in = 32'h000000B2;
    step();
    check("bp_b_z_hold", 32'(b4.z), 32'hA1);
    check("bp_b_in_ready", 32'(b4.in_ready), 32'h0);
    b4.in = 32'h000000C3;
    step();
    check("bp_c_z_hold", 32'(b4.z), 32'hA1);
    check("bp_c_in_ready", 32'(b4.in_ready), 32'h0);
    check("bp_c_out_valid", 32'(b4.out_valid), 32'h1);
    b4.out_ready = 1'b1;
    step();
    check("bp_pop_b_z", 32'(b4.z), 32'hB2);
    check("bp_pop_b_in_ready", 32'(b4.in_ready), 32'h1);
    step();
    check("bp_pop_c_z", 32'(b4.z), 32'hC3);
    check("bp_pop_c_out_valid", 32'(b4.out_valid), 32'h1);
    b4.in_valid = 1'b0;
    step();
    check("bp_empty_out_valid", 32'(b4.out_valid), 32'h0);
    check("bp_empty_z_held", 32'(b4.z), 32'hC3);

    // Sustained streaming: 16 beats back to back.
    for (int k = 0; k < 16; k++) begin
      beat = 8'(k * 7 + 3);
      b4.in = {24'h0, beat};
      b4.in_valid = 1'b1;
      step();
      check($sformatf("strm%0d_z", k),         32'(b4.z),         32'(beat));
      check($sformatf("strm%0d_out_valid", k), 32'(b4.out_valid), 32'h1);
      check($sformatf("strm%0d_in_ready", k),  32'(b4.in_ready),  32'h1);
    end
    b4.in_valid = 1'b0;
    step();
    check("strm_end_out_valid", 32'(b4.out_valid), 32'h0);

    // Exhaustive 2-channel 1-bit sweep.
    for (int s = 0; s < 4; s++) begin
      for (int d = 0; d < 4; d++) begin
        b2.sel = 2'(s);
        b2.in = 2'(d);
        b2.in_valid = 1'b1;
        b2.out_ready = 1'b1;
        step();
        e = ((s & 1) != 0 && (d & 1) != 0) || ((s & 2) != 0 && (d & 2) != 0);
        if (ONECHK && s == 3) exp_err2 = 1'b1;
        check($sformatf("sw_s%0d_d%0d_z", s, d), 32'(b2.z), 32'(e));
        check($sformatf("sw_s%0d_d%0d_ov", s, d), 32'(b2.out_valid), 32'h1);
      end
    end
    b2.in_valid = 1'b0;
    check("sw_error", 32'(b2.error), 32'(exp_err2));

    // Asynchronous reset while both entries are full.
    b4.sel = 4'b0101;
    b4.out_ready = 1'b0;
    b4.in_valid = 1'b1;
    b4.in = 32'h00110022;
    step();
    b4.in = 32'h00330044;
    step();
    check("pre_rst_in_ready", 32'(b4.in_ready), 32'h0);
    check("pre_rst_error", 32'(b4.error), 32'(ONECHK));
    nreset = 1'b0;
    #1;
    check("arst_out_valid", 32'(b4.out_valid), 32'h0);
    check("arst_z",         32'(b4.z),         32'h0);
    check("arst_in_ready",  32'(b4.in_ready),  32'h1);
    check("arst_error",     32'(b4.error),     32'h0);
    @(negedge clk);
    nreset = 1'b1;
    b4.sel = 4'b0001;
    b4.in = 32'h0000005C;
    b4.out_ready = 1'b1;
    step();
    check("post_rst_z", 32'(b4.z), 32'h5C);
    check("post_rst_out_valid", 32'(b4.out_valid), 32'h1);
    b4.in_valid = 1'b0;
    step();
    check("post_rst_drain", 32'(b4.out_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
